// File: rtl/sram_arbiter.sv
// Single-port asynchronous SRAM arbiter for three clients: a loader (write
// only), a CPU (read/write) and a PPU (read only). Each access walks
// IDLE -> SETUP -> STROBE (STROBE_CYCLES long) -> DONE, with the granted
// client's payload frozen at grant time so late request changes are harmless.
module sram_arbiter #(
    parameter int STROBE_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ldr_req,
    input  logic [17:0] ldr_addr,
    input  logic [7:0]  ldr_wdata,
    output logic        ldr_ack,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [17:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        ppu_req,
    input  logic [17:0] ppu_addr,
    output logic        ppu_ack,
    output logic [7:0]  ppu_rdata,
    output logic [17:0] sram_adr,
    output logic [15:0] sram_dout,
    input  logic [15:0] sram_din,
    output logic        sram_dq_oe,
    output logic        sram_cs_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;
    typedef enum logic [1:0] {SEL_LDR, SEL_CPU, SEL_PPU} sel_t;

    // Strobe down-counter reload value; the counter reaching zero marks the
    // final strobe cycle.
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

    state_t      state_q, state_d;
    sel_t        sel_q, sel_d;
    logic        we_q, we_d;
    logic [17:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    // 1 = PPU wins the next CPU/PPU tie, 0 = CPU wins it.
    logic        ppu_first_q, ppu_first_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic [7:0]  ppu_rdata_q, ppu_rdata_d;

    // Upper SRAM data byte is never used by any client.
    logic unused_din_hi;
    assign unused_din_hi = ^sram_din[15:8];

    // State and payload registers; reset aborts any access in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= SEL_LDR;
            we_q        <= 1'b0;
            addr_q      <= 18'd0;
            wdata_q     <= 8'h00;
            cnt_q       <= 4'd0;
            ppu_first_q <= 1'b1;
            cpu_rdata_q <= 8'h00;
            ppu_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            ppu_first_q <= ppu_first_d;
            cpu_rdata_q <= cpu_rdata_d;
            ppu_rdata_q <= ppu_rdata_d;
        end
    end

    // Next-state logic: arbitration in IDLE, strobe timing and read capture.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        ppu_first_d = ppu_first_q;
        cpu_rdata_d = cpu_rdata_q;
        ppu_rdata_d = ppu_rdata_q;

        case (state_q)
            IDLE: begin
                if (ldr_req) begin
                    // Loader always wins and leaves the CPU/PPU pointer alone.
                    sel_d   = SEL_LDR;
                    we_d    = 1'b1;
                    addr_d  = ldr_addr;
                    wdata_d = ldr_wdata;
                    state_d = SETUP;
                end else if (cpu_req && (!ppu_req || !ppu_first_q)) begin
                    sel_d       = SEL_CPU;
                    we_d        = cpu_we;
                    addr_d      = cpu_addr;
                    wdata_d     = cpu_wdata;
                    ppu_first_d = 1'b1;
                    state_d     = SETUP;
                end else if (ppu_req) begin
                    sel_d       = SEL_PPU;
                    we_d        = 1'b0;
                    addr_d      = ppu_addr;
                    ppu_first_d = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = STROBE_LAST;
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (sel_q == SEL_CPU) begin
                            cpu_rdata_d = sram_din[7:0];
                        end else if (sel_q == SEL_PPU) begin
                            ppu_rdata_d = sram_din[7:0];
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes decode straight from registered state, so they are glitch-free
    // relative to request inputs. Write data stays driven through DONE for
    // hold time; output enable is only ever asserted on reads.
    logic active;
    assign active     = (state_q == SETUP) || (state_q == STROBE);
    assign busy       = (state_q != IDLE);
    assign sram_cs_n  = !active;
    assign sram_oe_n  = !(active && !we_q);
    assign sram_we_n  = !((state_q == STROBE) && we_q);
    assign sram_dq_oe = we_q && busy;
    assign sram_adr   = addr_q;
    assign sram_dout  = {8'h00, wdata_q};

    assign ldr_ack   = (state_q == DONE) && (sel_q == SEL_LDR);
    assign cpu_ack   = (state_q == DONE) && (sel_q == SEL_CPU);
    assign ppu_ack   = (state_q == DONE) && (sel_q == SEL_PPU);
    assign cpu_rdata = cpu_rdata_q;
    assign ppu_rdata = ppu_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, auto-requesters that re-request
// after each ack, and a high-level ordering/data model of the arbiter.
`timescale 1ns/1ps
module tb_sram_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        ldr_req, ldr_ack, cpu_req, cpu_we, cpu_ack, ppu_req, ppu_ack;
    logic [17:0] ldr_addr, cpu_addr, ppu_addr, sram_adr;
    logic [7:0]  ldr_wdata, cpu_wdata, cpu_rdata, ppu_rdata, din_hi;
    logic [15:0] sram_dout, sram_din;
    logic        sram_dq_oe, sram_cs_n, sram_oe_n, sram_we_n, busy;

    // Second instance with a 3-cycle strobe; only its PPU port is exercised.
    logic        ldr_req3, ldr_ack3, cpu_req3, cpu_we3, cpu_ack3, ppu_req3, ppu_ack3;
    logic [17:0] ldr_addr3, cpu_addr3, ppu_addr3, sram_adr3;
    logic [7:0]  ldr_wdata3, cpu_wdata3, cpu_rdata3, ppu_rdata3;
    logic [15:0] sram_dout3, sram_din3;
    logic        sram_dq_oe3, sram_cs_n3, sram_oe_n3, sram_we_n3, busy3;

    logic [7:0] mem     [0:262143];
    logic [7:0] ref_mem [0:262143];

    assign sram_din  = {din_hi, mem[sram_adr]};
    assign sram_din3 = {8'h3C, mem[sram_adr3]};

    sram_arbiter #(.STROBE_CYCLES(1)) dut (
        .clock(clock), .reset(reset),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata),
        .sram_adr(sram_adr), .sram_dout(sram_dout), .sram_din(sram_din),
        .sram_dq_oe(sram_dq_oe), .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .busy(busy)
    );

    sram_arbiter #(.STROBE_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset),
        .ldr_req(ldr_req3), .ldr_addr(ldr_addr3), .ldr_wdata(ldr_wdata3), .ldr_ack(ldr_ack3),
        .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
        .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
        .ppu_req(ppu_req3), .ppu_addr(ppu_addr3), .ppu_ack(ppu_ack3), .ppu_rdata(ppu_rdata3),
        .sram_adr(sram_adr3), .sram_dout(sram_dout3), .sram_din(sram_din3),
        .sram_dq_oe(sram_dq_oe3), .sram_cs_n(sram_cs_n3), .sram_oe_n(sram_oe_n3),
        .sram_we_n(sram_we_n3), .busy(busy3)
    );

    typedef struct {
        int          who;       // 0 loader, 1 CPU, 2 PPU
        logic        we;
        logic [17:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;     // DUT rdata seen with the ack
        logic [7:0]  exp_rdata; // model memory contents at ack time
        logic [7:0]  mem_at;    // SRAM contents at addr just after the ack
        int          cyc;
    } ack_t;

    ack_t log_q[$];
    int   exp_who[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   inv_bad = 0;
    int   oe_low = 0, we_low = 0, oe3_low = 0, ack3_cyc = -1;
    int   ldr_left = 0, cpu_left = 0, ppu_left = 0;
    bit   m_ppu_first = 1'b1;

    task automatic new_ldr();
        ldr_addr  = 18'($urandom);
        ldr_wdata = 8'($urandom);
    endtask

    task automatic new_cpu();
        cpu_we    = 1'($urandom);
        cpu_addr  = 18'($urandom);
        cpu_wdata = 8'($urandom);
    endtask

    task automatic new_ppu();
        ppu_addr = 18'($urandom);
    endtask

    // One clock: SRAM write model, edge, then sample/monitor 1ns after.
    task automatic tick();
        ack_t e;
        if (!sram_we_n && !sram_cs_n) mem[sram_adr] = sram_dout[7:0];
        @(posedge clock);
        #1;
        cyc++;
        if (32'(ldr_ack) + 32'(cpu_ack) + 32'(ppu_ack) > 1) inv_bad++;
        if (!sram_we_n && !sram_oe_n) inv_bad++;
        if (sram_dq_oe && !sram_oe_n) inv_bad++;
        if (!busy && (!sram_cs_n || !sram_oe_n || !sram_we_n || sram_dq_oe)) inv_bad++;
        if (!sram_we_n3 && !sram_oe_n3) inv_bad++;
        if (sram_dq_oe3 && !sram_oe_n3) inv_bad++;
        if (!sram_oe_n) oe_low++;
        if (!sram_we_n) we_low++;
        if (!sram_oe_n3) oe3_low++;
        if (ppu_ack3) begin
            ack3_cyc = cyc;
            ppu_req3 = 1'b0;
        end
        if (ldr_ack) begin
            e.who = 0; e.we = 1'b1; e.addr = ldr_addr; e.wdata = ldr_wdata;
            e.rdata = 8'h00; e.exp_rdata = 8'h00;
            ref_mem[ldr_addr] = ldr_wdata;
            e.mem_at = mem[ldr_addr]; e.cyc = cyc;
            log_q.push_back(e);
            if (ldr_left > 0) ldr_left--;
            if (ldr_left > 0) new_ldr(); else ldr_req = 1'b0;
        end
        if (cpu_ack) begin
            e.who = 1; e.we = cpu_we; e.addr = cpu_addr; e.wdata = cpu_wdata;
            e.rdata = cpu_rdata;
            e.exp_rdata = cpu_we ? 8'h00 : ref_mem[cpu_addr];
            if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
            e.mem_at = mem[cpu_addr]; e.cyc = cyc;
            log_q.push_back(e);
            if (cpu_left > 0) cpu_left--;
            if (cpu_left > 0) new_cpu(); else cpu_req = 1'b0;
        end
        if (ppu_ack) begin
            e.who = 2; e.we = 1'b0; e.addr = ppu_addr; e.wdata = 8'h00;
            e.rdata = ppu_rdata; e.exp_rdata = ref_mem[ppu_addr];
            e.mem_at = mem[ppu_addr]; e.cyc = cyc;
            log_q.push_back(e);
            if (ppu_left > 0) ppu_left--;
            if (ppu_left > 0) new_ppu(); else ppu_req = 1'b0;
        end
    endtask

    task automatic run(input int n, input int budget);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        tick();
    endtask

    // Raise l/c/p outstanding requests in the same cycle with fresh payloads.
    task automatic start(input int l, input int c, input int p);
        log_q.delete();
        ldr_left = l; cpu_left = c; ppu_left = p;
        if (l > 0) new_ldr();
        if (c > 0) new_cpu();
        if (p > 0) new_ppu();
        ldr_req = (l > 0);
        cpu_req = (c > 0);
        ppu_req = (p > 0);
    endtask

    // Expected ack order: loader drains first; CPU/PPU alternate on ties,
    // whichever is alone is served directly.
    task automatic build_order(input int l, input int c, input int p);
        exp_who.delete();
        while (l + c + p > 0) begin
            if (l > 0) begin
                exp_who.push_back(0); l--;
            end else if (c > 0 && (p == 0 || !m_ppu_first)) begin
                exp_who.push_back(1); c--; m_ppu_first = 1'b1;
            end else begin
                exp_who.push_back(2); p--; m_ppu_first = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        ldr_req = 1'b0; cpu_req = 1'b0; ppu_req = 1'b0; ppu_req3 = 1'b0;
        ldr_left = 0; cpu_left = 0; ppu_left = 0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        m_ppu_first = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_req = 1'b1; ppu_req = 1'b1; ldr_req = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, ldr_ack, cpu_ack, ppu_ack} !== 4'b0000) begin
            errors++; $display("FAIL reset_busy_acks: got %b want 0000", {busy, ldr_ack, cpu_ack, ppu_ack});
        end
        checks++;
        if ({sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
            errors++; $display("FAIL reset_strobes: got %b want 1110", {sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe});
        end
        checks++;
        if ({cpu_rdata, ppu_rdata} !== 16'h0000) begin
            errors++; $display("FAIL reset_rdata: got %h want 0000", {cpu_rdata, ppu_rdata});
        end
        checks++;
        if (sram_adr !== 18'd0 || sram_dout !== 16'h0000) begin
            errors++; $display("FAIL reset_adr_dout: got %h/%h want 0/0", sram_adr, sram_dout);
        end
        checks++;
        if (busy3 !== 1'b0) begin
            errors++; $display("FAIL reset_busy3: got %b want 0", busy3);
        end
        do_reset();
        $display("test_reset done at cycle %0d", cyc);
    endtask

    task automatic test_cpu_read();
        int c0;
        logic [7:0] ppu_prev;
        mem[18'h00123] = 8'h5C; ref_mem[18'h00123] = 8'h5C; din_hi = 8'hAB;
        ppu_prev = ppu_rdata;
        start(0, 1, 0);
        cpu_we = 1'b0; cpu_addr = 18'h00123;
        build_order(0, 1, 0);
        oe_low = 0; we_low = 0; c0 = cyc;
        run(1, 20);
        repeat (3) tick();
        checks++;
        if (log_q.size() != 1) begin
            errors++; $display("FAIL cpu_read_ack_count: got %0d want 1", log_q.size());
        end
        if (log_q.size() > 0) begin
            checks++;
            if (log_q[0].who != 1 || log_q[0].cyc - c0 != 3) begin
                errors++; $display("FAIL cpu_read_latency: got who %0d at +%0d want who 1 at +3", log_q[0].who, log_q[0].cyc - c0);
            end
            checks++;
            if (log_q[0].rdata !== 8'h5C) begin
                errors++; $display("FAIL cpu_read_data: got %h want 5c", log_q[0].rdata);
            end
        end
        checks++;
        if (oe_low != 2 || we_low != 0) begin
            errors++; $display("FAIL cpu_read_strobes: got oe_low %0d we_low %0d want 2 0", oe_low, we_low);
        end
        checks++;
        if (cpu_rdata !== 8'h5C || ppu_rdata !== ppu_prev) begin
            errors++; $display("FAIL cpu_read_hold: got %h/%h want 5c/%h", cpu_rdata, ppu_rdata, ppu_prev);
        end
        $display("test_cpu_read done: %0d acks", log_q.size());
    endtask

    task automatic test_tie();
        do_reset();
        start(0, 1, 2);
        cpu_we = 1'b1; cpu_addr = 18'h00010; cpu_wdata = 8'h77;
        build_order(0, 1, 2);
        run(3, 60);
        checks++;
        if (log_q.size() != 3) begin
            errors++; $display("FAIL tie_count: got %0d want 3", log_q.size());
        end
        for (int i = 0; i < log_q.size() && i < exp_who.size(); i++) begin
            checks++;
            if (log_q[i].who != exp_who[i]) begin
                errors++; $display("FAIL tie_order[%0d]: got %0d want %0d", i, log_q[i].who, exp_who[i]);
            end
        end
        checks++;
        if (mem[18'h00010] !== 8'h77) begin
            errors++; $display("FAIL tie_write: got %h want 77", mem[18'h00010]);
        end
        $display("test_tie done: %0d acks", log_q.size());
    endtask

    task automatic test_ldr_priority();
        start(4, 3, 3);
        build_order(4, 3, 3);
        run(10, 200);
        checks++;
        if (log_q.size() != 10) begin
            errors++; $display("FAIL ldr_count: got %0d want 10", log_q.size());
        end
        for (int i = 0; i < log_q.size() && i < exp_who.size(); i++) begin
            checks++;
            if (log_q[i].who != exp_who[i]) begin
                errors++; $display("FAIL ldr_order[%0d]: got %0d want %0d", i, log_q[i].who, exp_who[i]);
            end
            if (log_q[i].who == 0) begin
                checks++;
                if (log_q[i].mem_at !== log_q[i].wdata) begin
                    errors++; $display("FAIL ldr_write[%0d]: got %h want %h", i, log_q[i].mem_at, log_q[i].wdata);
                end
            end
        end
        $display("test_ldr_priority done: %0d acks", log_q.size());
    endtask

    task automatic test_reset_abort();
        int c_rel;
        logic [17:0] a;
        a = 18'h2A5A5;
        mem[a] = 8'hA5; ref_mem[a] = 8'hA5;
        start(0, 1, 0);
        cpu_we = 1'b0; cpu_addr = a;
        build_order(0, 1, 0);
        run(1, 20);
        start(0, 1, 0);
        cpu_we = 1'b1;
        tick(); tick();
        checks++;
        if (sram_we_n !== 1'b0 || cpu_rdata !== 8'hA5) begin
            errors++; $display("FAIL abort_in_strobe: got we_n %b rdata %h want 0 a5", sram_we_n, cpu_rdata);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe, busy, cpu_ack} !== 6'b111000) begin
            errors++; $display("FAIL abort_outputs: got %b want 111000", {sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe, busy, cpu_ack});
        end
        checks++;
        if (cpu_rdata !== 8'h00) begin
            errors++; $display("FAIL abort_rdata: got %h want 00", cpu_rdata);
        end
        reset = 1'b0; m_ppu_first = 1'b1;
        c_rel = cyc;
        build_order(0, 1, 0);
        run(1, 20);
        checks++;
        if (log_q.size() != 1) begin
            errors++; $display("FAIL abort_count: got %0d want 1", log_q.size());
        end else begin
            checks++;
            if (log_q[0].who != 1 || log_q[0].cyc - c_rel != 3 || log_q[0].mem_at !== log_q[0].wdata) begin
                errors++; $display("FAIL abort_reissue: got who %0d +%0d mem %h want 1 +3 %h",
                                   log_q[0].who, log_q[0].cyc - c_rel, log_q[0].mem_at, log_q[0].wdata);
            end
        end
        $display("test_reset_abort done: %0d acks", log_q.size());
    endtask

    task automatic test_strobe3();
        int c0;
        logic [17:0] a;
        a = 18'($urandom);
        mem[a] = 8'($urandom);
        ppu_addr3 = a; ppu_req3 = 1'b1;
        oe3_low = 0; ack3_cyc = -1; c0 = cyc;
        for (int k = 0; k < 20 && ack3_cyc < 0; k++) tick();
        tick();
        checks++;
        if (ack3_cyc - c0 != 5) begin
            errors++; $display("FAIL strobe3_latency: got +%0d want +5", ack3_cyc - c0);
        end
        checks++;
        if (oe3_low != 4) begin
            errors++; $display("FAIL strobe3_oe_low: got %0d want 4", oe3_low);
        end
        checks++;
        if (ppu_rdata3 !== mem[a]) begin
            errors++; $display("FAIL strobe3_data: got %h want %h", ppu_rdata3, mem[a]);
        end
        $display("test_strobe3 done: ack at +%0d", ack3_cyc - c0);
    endtask

    task automatic test_continuous();
        int bad0;
        bad0 = inv_bad;
        start(0, 50, 50);
        build_order(0, 50, 50);
        run(100, 800);
        checks++;
        if (log_q.size() != 100) begin
            errors++; $display("FAIL cont_count: got %0d want 100", log_q.size());
        end
        for (int i = 0; i < log_q.size() && i < exp_who.size(); i++) begin
            checks++;
            if (log_q[i].who != exp_who[i]) begin
                errors++; $display("FAIL cont_order[%0d]: got %0d want %0d", i, log_q[i].who, exp_who[i]);
            end
            if (i > 0) begin
                checks++;
                if (log_q[i].cyc - log_q[i-1].cyc != 4) begin
                    errors++; $display("FAIL cont_spacing[%0d]: got %0d want 4", i, log_q[i].cyc - log_q[i-1].cyc);
                end
            end
        end
        checks++;
        if (inv_bad != bad0) begin
            errors++; $display("FAIL cont_invariants: got %0d violations want 0", inv_bad - bad0);
        end
        $display("test_continuous done: %0d acks", log_q.size());
    endtask

    task automatic test_random_mix();
        for (int r = 0; r < 4; r++) begin
            int l, c, p, n;
            l = $urandom_range(0, 3); c = $urandom_range(0, 4); p = $urandom_range(1, 4);
            n = l + c + p;
            din_hi = 8'($urandom);
            start(l, c, p);
            build_order(l, c, p);
            run(n, 40 * n);
            checks++;
            if (log_q.size() != n) begin
                errors++; $display("FAIL mix%0d_count: got %0d want %0d", r, log_q.size(), n);
            end
            for (int i = 0; i < log_q.size() && i < exp_who.size(); i++) begin
                checks++;
                if (log_q[i].who != exp_who[i]) begin
                    errors++; $display("FAIL mix%0d_order[%0d]: got %0d want %0d", r, i, log_q[i].who, exp_who[i]);
                end
                checks++;
                if (log_q[i].we && log_q[i].mem_at !== log_q[i].wdata) begin
                    errors++; $display("FAIL mix%0d_write[%0d]: got %h want %h", r, i, log_q[i].mem_at, log_q[i].wdata);
                end else if (!log_q[i].we && log_q[i].rdata !== log_q[i].exp_rdata) begin
                    errors++; $display("FAIL mix%0d_read[%0d]: got %h want %h", r, i, log_q[i].rdata, log_q[i].exp_rdata);
                end
            end
            $display("test_random_mix round %0d: l%0d c%0d p%0d, %0d acks", r, l, c, p, log_q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        ldr_req = 1'b0; ldr_addr = '0; ldr_wdata = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ppu_req = 1'b0; ppu_addr = '0; din_hi = 8'h00;
        ldr_req3 = 1'b0; ldr_addr3 = '0; ldr_wdata3 = '0;
        cpu_req3 = 1'b0; cpu_we3 = 1'b0; cpu_addr3 = '0; cpu_wdata3 = '0;
        ppu_req3 = 1'b0; ppu_addr3 = '0;
        for (int i = 0; i < 262144; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_cpu_read();
        test_tie();
        test_ldr_priority();
        test_reset_abort();
        test_strobe3();
        test_continuous();
        test_random_mix();
        checks++;
        if (inv_bad != 0) begin
            errors++; $display("FAIL invariants: got %0d violations want 0", inv_bad);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter STROBE_CYCLES, default 1, giving the number of cycles RAMOE_n/RAMWE_n are held active per access (legal range 1-15).
REQ-002 The block SHALL have these ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- ldr_req  in  1  loader write request, level, held until ldr_ack
- ldr_addr  in  18  loader byte address
- ldr_wdata  in  8  loader write data
- ldr_ack  out  1  one-cycle pulse, write complete
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  18  CPU byte address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle pulse, access complete
- cpu_rdata  out  8  CPU read data, valid while cpu_ack=1, held until next CPU read completes
- ppu_req  in  1  PPU read request, level, held until ppu_ack
- ppu_addr  in  18  PPU byte address
- ppu_ack  out  1  one-cycle pulse, read complete
- ppu_rdata  out  8  PPU read data, same validity rule as cpu_rdata
- sram_adr  out  18  SRAM address
- sram_dout  out  16  SRAM write data, {8'h00, wdata}
- sram_din  in  16  SRAM read data; only [7:0] used
- sram_dq_oe  out  1  1 = top level drives DAT with sram_dout
- sram_cs_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active low
- busy  out  1  1 whenever state is not IDLE

Function
REQ-003 The FSM SHALL have states IDLE, SETUP, STROBE, DONE.
REQ-004 In IDLE, if any request is high, the arbiter SHALL grant one requester, register its address/data/direction, and enter SETUP the next cycle; otherwise it stays in IDLE.
REQ-005 Grant priority SHALL be: ldr_req highest, unconditionally; between cpu_req and ppu_req, round-robin, with the requester not granted last winning a tie; after reset the PPU wins the first tie.
REQ-006 A single pending CPU or PPU request SHALL be granted immediately regardless of round-robin pointer; the pointer updates only on CPU/PPU grants, not loader grants.
REQ-007 SETUP SHALL last 1 cycle: sram_cs_n=0, sram_adr valid; for writes sram_dq_oe=1, sram_dout valid; for reads sram_oe_n=0.
REQ-008 STROBE SHALL last exactly STROBE_CYCLES cycles (internal down-counter): sram_cs_n=0; writes have sram_we_n=0 and sram_dq_oe=1; reads have sram_oe_n=0; address/data stable.
REQ-009 For reads, sram_din[7:0] SHALL be captured on the last STROBE cycle into the granted requester's rdata register; the other rdata register stays unchanged.
REQ-010 DONE SHALL last 1 cycle: the granted requester's ack=1, sram_we_n=1, sram_oe_n=1, sram_cs_n=1; writes hold sram_dq_oe=1 and address/data stable (hold time); FSM returns to IDLE.
REQ-011 Latency from a request sampled high in IDLE at cycle T to its ack SHALL be T+2+STROBE_CYCLES (T+3 at default); per-access throughput is one access per 3+STROBE_CYCLES cycles.
REQ-012 At most one ack SHALL be high in any cycle; the ack SHALL never assert for a requester not granted.
REQ-013 A requester whose req is high in the IDLE cycle after its own ack SHALL be treated as a new request.
REQ-014 Requests dropped before grant SHALL be ignored; request inputs and payload changing after grant SHALL NOT affect the access in flight.
REQ-015 sram_we_n and sram_oe_n SHALL never be 0 simultaneously; sram_dq_oe SHALL be 0 whenever sram_oe_n=0.
REQ-016 In IDLE all strobes SHALL be 1, sram_dq_oe=0, busy=0.

Reset
REQ-017 On reset=1 at a clock edge, the block SHALL enter IDLE on that edge, aborting any access: acks=0, strobes=1, sram_dq_oe=0, busy=0, cpu_rdata=ppu_rdata=8'h00, sram_adr=0, sram_dout=0, round-robin pointer = PPU-first.
REQ-018 No ack SHALL be issued for an access aborted by reset.

Verification
REQ-019 CPU read, addr 18'h00123, SRAM model returns 16'hAB5C -> cpu_ack at T+3, cpu_rdata=8'h5C, sram_oe_n low 2 cycles, sram_we_n never low.
REQ-020 cpu_req (write 8'h77 @18'h00010) and ppu_req rise same cycle after reset -> PPU served first, then CPU; SRAM location 18'h00010 = 8'h77; second tie -> CPU first.
REQ-021 ldr_req held with cpu_req and ppu_req for 4 accesses -> all 4 loader writes complete before any CPU/PPU ack.
REQ-022 STROBE_CYCLES=3, PPU read -> sram_oe_n low 4 cycles, ppu_ack at T+5.
REQ-023 reset asserted during STROBE of a CPU write -> next cycle all strobes high, dq_oe=0, no cpu_ack; re-issued request completes normally.
REQ-024 Continuous cpu_req and ppu_req for 100 accesses -> acks strictly alternate, assertion checks for REQ-012 and REQ-015 never fire.
